// File: rtl/esfa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : esfa_pkg
// Purpose  : Shared definitions for the ESFA command arbiter: command word
//            field offsets, result-latency limits and the arbiter state
//            encoding.
// Revision : 1.0 - initial release
// ============================================================================
package esfa_pkg;

    // Command word field layout (40-bit ESFA command)
    localparam int FIELD_W     = 8;
    localparam int IDX_LSB     = 8;
    localparam int VAL_LSB     = 16;
    localparam int META_LSB    = 24;
    localparam int SEL_LSB     = 32;
    localparam int BIT_MUTATE  = 0;
    localparam int BIT_IS_META = 3;

    // Result latency limits; the wait counter is sized for RES_LAT_MAX
    localparam int RES_LAT_MIN = 1;
    localparam int RES_LAT_MAX = 15;
    localparam int WAIT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage : esfa_pkg
`default_nettype wire

// File: rtl/esfa_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : esfa_rr_picker
// Purpose  : Combinational round-robin pick. Scans i_req starting at i_ptr,
//            wrapping modulo NUM_REQ, and returns the first set requester.
// Ports    : i_req   [NUM_REQ]  request vector
//            i_ptr   [IDX_W]    index with highest priority this cycle
//            o_grant [NUM_REQ]  one-hot winner (all zero if no request)
//            o_idx   [IDX_W]    binary index of the winner
// Revision : 1.0 - initial release
// ============================================================================
module esfa_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    logic             w_found;
    logic [IDX_W:0]   w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit so ptr+k cannot overflow before the modulo fold
            w_cand = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                o_idx   = w_cand[IDX_W-1:0];
            end
        end
        o_grant = w_found ? (NUM_REQ'(1) << o_idx) : '0;
    end

endmodule : esfa_rr_picker
`default_nettype wire

// File: rtl/esfa_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : esfa_cmd_arbiter
// Purpose  : Shares one ESFA datapath between NUM_REQ command requesters.
//            Round-robin grant, one-cycle command strobe, RES_LAT-cycle wait,
//            then a valid/ready response to the granted requester.
// Ports    : clk, reset (async, active-high)
//            req_valid/req_ready/req_cmd   - per-requester command channel
//            rsp_valid/rsp_ready           - per-requester response channel
//            rsp_bool/rsp_value            - shared response payload
//            esfa_*                        - datapath command fields / results
//            busy                          - arbiter not idle
//            perf_grant_cnt                - per-requester grant counters
// Config   : ESFA_ARB_PERF_EN enables saturating grant counters; otherwise
//            perf_grant_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module esfa_cmd_arbiter
    import esfa_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CMD_W   = 40,
    parameter int RES_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic                     rsp_bool,
    output logic [7:0]               rsp_value,
    output logic                     esfa_cmd_valid,
    output logic [7:0]               esfa_new_index,
    output logic [7:0]               esfa_new_value,
    output logic [7:0]               esfa_metadata,
    output logic                     esfa_is_metadata,
    output logic [7:0]               esfa_selector,
    input  logic                     esfa_result_bool,
    input  logic [7:0]               esfa_result_value,
    output logic                     busy,
    output logic [NUM_REQ*CNT_W-1:0] perf_grant_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              rsp_bool_q, rsp_bool_d;
    logic [7:0]        rsp_value_q, rsp_value_d;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic [CMD_W-1:0]   w_owner_cmd;
    logic               w_issue;
    logic               w_unused_cmd;

    esfa_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (rr_ptr_q),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    assign w_owner_oh  = NUM_REQ'(1) << owner_q;
    assign w_issue     = (state_q == ST_ISSUE);
    // The owner holds its command stable until req_ready, so the ISSUE-cycle
    // fields come straight from its req_cmd slice without a holding register.
    assign w_owner_cmd = req_cmd[int'(owner_q)*CMD_W +: CMD_W];
    // Reserved/mutate bits are not routed to the datapath
    assign w_unused_cmd = ^w_owner_cmd;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_bool_d  = rsp_bool_q;
        rsp_value_d = rsp_value_q;
        case (state_q)
            ST_IDLE: begin
                if (|w_pick_grant) begin
                    owner_d = w_pick_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rr_ptr_d   = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
                wait_cnt_d = WAIT_W'(RES_LAT-1);
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    rsp_bool_d  = esfa_result_bool;
                    rsp_value_d = esfa_result_value;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            wait_cnt_q  <= '0;
            rsp_bool_q  <= 1'b0;
            rsp_value_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_bool_q  <= rsp_bool_d;
            rsp_value_q <= rsp_value_d;
        end
    end

    assign req_ready = w_issue ? w_owner_oh : '0;
    assign rsp_valid = (state_q == ST_RESP) ? w_owner_oh : '0;
    assign rsp_bool  = rsp_bool_q;
    assign rsp_value = rsp_value_q;
    assign busy      = (state_q != ST_IDLE);

    // Fields forced to zero outside ISSUE so the datapath never sees a
    // stale command
    assign esfa_cmd_valid   = w_issue;
    assign esfa_new_index   = w_issue ? w_owner_cmd[IDX_LSB  +: FIELD_W] : '0;
    assign esfa_new_value   = w_issue ? w_owner_cmd[VAL_LSB  +: FIELD_W] : '0;
    assign esfa_metadata    = w_issue ? w_owner_cmd[META_LSB +: FIELD_W] : '0;
    assign esfa_selector    = w_issue ? w_owner_cmd[SEL_LSB  +: FIELD_W] : '0;
    assign esfa_is_metadata = w_issue & w_owner_cmd[BIT_IS_META];

`ifdef ESFA_ARB_PERF_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (w_issue && (owner_q == IDX_W'(gi)) && !(&cnt_q)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign perf_grant_cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
`else
    assign perf_grant_cnt = '0;
`endif

endmodule : esfa_cmd_arbiter
`default_nettype wire

// File: tb/tb_esfa_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_esfa_cmd_arbiter
// Purpose  : Directed self-checking bench for esfa_cmd_arbiter. Instance A
//            uses RES_LAT=1/CNT_W=16, instance B uses RES_LAT=4/CNT_W=4.
//            Each instance drives a small datapath model whose result is
//            only correct once the configured latency has elapsed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_esfa_cmd_arbiter;

`ifdef ESFA_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int LAT_A = 1;
    localparam int LAT_B = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // ---------------- instance A ----------------
    logic [3:0]   a_req_valid = '0, a_req_ready, a_rsp_valid, a_rsp_ready = '0;
    logic [159:0] a_req_cmd = '0;
    logic         a_rsp_bool, a_cmd_valid, a_is_meta, a_busy, a_res_bool;
    logic [7:0]   a_rsp_value, a_idx, a_val, a_meta, a_sel, a_res_value;
    logic [63:0]  a_perf;

    esfa_cmd_arbiter #(.NUM_REQ(4), .CMD_W(40), .RES_LAT(LAT_A), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_cmd(a_req_cmd),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_bool(a_rsp_bool), .rsp_value(a_rsp_value),
        .esfa_cmd_valid(a_cmd_valid), .esfa_new_index(a_idx), .esfa_new_value(a_val),
        .esfa_metadata(a_meta), .esfa_is_metadata(a_is_meta), .esfa_selector(a_sel),
        .esfa_result_bool(a_res_bool), .esfa_result_value(a_res_value),
        .busy(a_busy), .perf_grant_cnt(a_perf)
    );

    // ---------------- instance B ----------------
    logic [3:0]   b_req_valid = '0, b_req_ready, b_rsp_valid, b_rsp_ready = '0;
    logic [159:0] b_req_cmd = '0;
    logic         b_rsp_bool, b_cmd_valid, b_is_meta, b_busy, b_res_bool;
    logic [7:0]   b_rsp_value, b_idx, b_val, b_meta, b_sel, b_res_value;
    logic [15:0]  b_perf;

    esfa_cmd_arbiter #(.NUM_REQ(4), .CMD_W(40), .RES_LAT(LAT_B), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_cmd(b_req_cmd),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_bool(b_rsp_bool), .rsp_value(b_rsp_value),
        .esfa_cmd_valid(b_cmd_valid), .esfa_new_index(b_idx), .esfa_new_value(b_val),
        .esfa_metadata(b_meta), .esfa_is_metadata(b_is_meta), .esfa_selector(b_sel),
        .esfa_result_bool(b_res_bool), .esfa_result_value(b_res_value),
        .busy(b_busy), .perf_grant_cnt(b_perf)
    );

    // Datapath models: value = new_value ^ new_index, bool = selector[0],
    // valid only LAT cycles after the strobe; 0x3C before that.
    logic [7:0] a_m_val = '0, b_m_val = '0;
    logic       a_m_bool = 1'b0, b_m_bool = 1'b0;
    int         a_m_cnt = 0, b_m_cnt = 0;

    always @(posedge clk) begin
        if (a_cmd_valid) begin
            a_m_val <= a_val ^ a_idx; a_m_bool <= a_sel[0]; a_m_cnt <= 1;
        end else if (a_m_cnt != 0 && a_m_cnt < LAT_A) begin
            a_m_cnt <= a_m_cnt + 1;
        end
        if (b_cmd_valid) begin
            b_m_val <= b_val ^ b_idx; b_m_bool <= b_sel[0]; b_m_cnt <= 1;
        end else if (b_m_cnt != 0 && b_m_cnt < LAT_B) begin
            b_m_cnt <= b_m_cnt + 1;
        end
    end
    assign a_res_value = (a_m_cnt >= LAT_A) ? a_m_val : 8'h3C;
    assign a_res_bool  = (a_m_cnt >= LAT_A) ? a_m_bool : 1'b0;
    assign b_res_value = (b_m_cnt >= LAT_B) ? b_m_val : 8'h3C;
    assign b_res_bool  = (b_m_cnt >= LAT_B) ? b_m_bool : 1'b0;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [7:0] sel, input logic [7:0] meta,
                                       input logic [7:0] val, input logic [7:0] idx,
                                       input logic [7:0] low);
        return {sel, meta, val, idx, low};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        a_req_valid = '0; a_rsp_ready = '0;
        b_req_valid = '0; b_rsp_ready = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Wait (bounded) for a grant, check owner, wait for response, check it,
    // then complete the response handshake.
    task automatic a_run(input int own, input logic [7:0] v, input logic bb, input bit drop);
        int n = 0;
        while (a_req_ready == '0 && n < 20) begin tick(); n++; end
        check("a_grant", a_req_ready, 64'(4'b0001 << own));
        tick();
        if (drop) a_req_valid[own] = 1'b0;
        n = 0;
        while (a_rsp_valid == '0 && n < 20) begin tick(); n++; end
        check("a_rsp_valid", a_rsp_valid, 64'(4'b0001 << own));
        check("a_rsp_data", {a_rsp_bool, a_rsp_value}, {bb, v});
        a_rsp_ready = 4'b1111;
        tick();
        a_rsp_ready = '0;
    endtask

    task automatic b_run(input int own, input logic [7:0] v, input logic bb);
        int n = 0;
        while (b_req_ready == '0 && n < 20) begin tick(); n++; end
        check("b_grant", b_req_ready, 64'(4'b0001 << own));
        n = 0;
        do begin tick(); n++; end while (b_rsp_valid == '0 && n < 20);
        check("b_issue_to_rsp", n, LAT_B + 1);
        check("b_rsp_data", {b_rsp_valid, b_rsp_bool, b_rsp_value}, {4'b0001 << own, bb, v});
        b_rsp_ready = 4'b0001 << own;
        tick();
        b_rsp_ready = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic seen;
        logic [7:0] held;

        // Reset state
        tick(); tick();
        check("reset_outputs", {a_req_ready, a_rsp_valid, a_busy, a_cmd_valid, a_sel,
                                a_rsp_bool, a_rsp_value}, '0);
        check("reset_perf", a_perf, '0);
        reset = 1'b0;

        // Single command from requester 0, RES_LAT=1
        a_req_cmd[0 +: 40] = mk(8'h05, 8'h33, 8'h44, 8'h22, 8'h08);
        a_req_valid = 4'b0001;
        tick();
        check("t1_issue", {a_cmd_valid, a_req_ready, a_busy}, {1'b1, 4'b0001, 1'b1});
        check("t1_fields", {a_sel, a_meta, a_val, a_idx, a_is_meta},
              {8'h05, 8'h33, 8'h44, 8'h22, 1'b1});
        tick();
        a_req_valid = '0;
        check("t1_wait_quiet", {a_cmd_valid, a_sel, a_meta, a_val, a_idx, a_is_meta,
                                a_req_ready, a_rsp_valid}, '0);
        tick();
        check("t1_rsp", {a_rsp_valid, a_rsp_bool, a_rsp_value}, {4'b0001, 1'b1, 8'h66});
        a_rsp_ready = 4'b1110;
        tick();
        check("t1_nonowner_ready", a_rsp_valid, 4'b0001);
        a_rsp_ready = 4'b0001;
        tick();
        a_rsp_ready = '0;
        check("t1_back_idle", {a_busy, a_rsp_valid}, '0);

        // Round robin, all four valid continuously
        do_reset();
        for (int i = 0; i < 4; i++)
            a_req_cmd[i*40 +: 40] = mk(8'h10 + 8'(i), 8'h00, 8'h40 + 8'(3*i), 8'h20, 8'h00);
        a_req_valid = 4'b1111;
        a_run(0, 8'h60, 1'b0, 1'b0);
        a_run(1, 8'h63, 1'b1, 1'b0);
        a_run(2, 8'h66, 1'b0, 1'b0);
        a_run(3, 8'h69, 1'b1, 1'b0);
        check("rr_perf_after4", a_perf, PERF ? 64'h0001_0001_0001_0001 : 64'h0);
        a_run(0, 8'h60, 1'b0, 1'b0);
        a_req_valid = '0;

        // Response back-pressure on requester 2, requester 0 waiting
        do_reset();
        a_req_cmd[2*40 +: 40] = mk(8'h0A, 8'h00, 8'h5A, 8'h0F, 8'h00);
        a_req_cmd[0 +: 40]    = mk(8'h01, 8'h00, 8'h12, 8'h34, 8'h01);
        a_req_valid = 4'b0100;
        tick();
        check("bp_grant2", a_req_ready, 4'b0100);
        tick();
        a_req_valid = 4'b0001;
        tick();
        check("bp_rsp", {a_rsp_valid, a_rsp_bool, a_rsp_value}, {4'b0100, 1'b0, 8'h55});
        held = a_rsp_value;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_rsp_valid != 4'b0100 || a_rsp_value != 8'h55 || a_req_ready != '0 ||
                a_cmd_valid || !a_busy) seen = 1'b1;
        end
        check("bp_hold_10", {seen, a_rsp_value}, {1'b0, held});
        a_rsp_ready = 4'b0100;
        tick();
        a_rsp_ready = '0;
        // rr_ptr is now 3; scan 3 -> 0 picks requester 0
        a_run(0, 8'h26, 1'b1, 1'b1);

        // Asynchronous reset while waiting for the result
        do_reset();
        a_req_cmd[1*40 +: 40] = mk(8'h07, 8'h00, 8'h99, 8'h01, 8'h00);
        a_req_valid = 4'b0010;
        tick();
        check("rst_grant1", a_req_ready, 4'b0010);
        tick();
        a_req_valid = '0;
        check("rst_in_wait", {a_busy, a_rsp_valid}, {1'b1, 4'b0000});
        #3 reset = 1'b1;
        #1;
        check("rst_async_zero", {a_busy, a_rsp_valid, a_req_ready, a_cmd_valid,
                                 a_rsp_bool, a_rsp_value}, '0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_rsp_valid != '0 || a_busy) seen = 1'b1;
        end
        check("rst_no_rsp_after", seen, 1'b0);

        // RES_LAT=4 instance
        do_reset();
        b_req_cmd[0 +: 40] = mk(8'h81, 8'h00, 8'hA5, 8'h00, 8'h00);
        b_req_valid = 4'b0001;
        b_run(0, 8'hA5, 1'b1);
        b_req_valid = '0;

        // Counter saturation: 20 grants to requester 1 on the 4-bit instance
        b_req_cmd[1*40 +: 40] = mk(8'h02, 8'h00, 8'h11, 8'h01, 8'h00);
        b_req_valid = 4'b0010;
        for (int g = 1; g <= 20; g++) begin
            b_run(1, 8'h10, 1'b0);
            if (g == 3) check("perf_cnt_3", b_perf[7:4], PERF ? 4'h3 : 4'h0);
        end
        b_req_valid = '0;
        check("perf_saturate", b_perf, PERF ? 16'h00F1 : 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_esfa_cmd_arbiter
`default_nettype wire
